// File: rtl/char_glyph_server.sv
// char_glyph_server
// Double-buffered glyph row fetcher for a character drawing block.
// A fetch request latches {charCode, rowCnt} as the glyph memory address,
// runs a REQ/WAIT handshake and drops the returned row into a shadow
// buffer. At each cell boundary (colCnt == 7) the shadow row is promoted
// to the active row, which is then serialised one pixel per cycle.
//
// Build option: define GLYPH_ACK_TIMEOUT_EN to abort fetches whose
// acknowledge does not arrive within ACK_TIMEOUT WAIT cycles. An aborted
// fetch delivers a blank row and pulses fetchErr.
module char_glyph_server #(
    parameter int ACK_TIMEOUT = 15,
    parameter int MSB_LEFT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        readEn,
    input  logic [3:0]  rowCnt,
    input  logic [2:0]  colCnt,
    input  logic [6:0]  charCode,
    output logic        memReq,
    output logic [10:0] memAddr,
    input  logic        memAck,
    input  logic [7:0]  memData,
    output logic        bitDisp,
    output logic        overrun,
    output logic        underrun,
    output logic        fetchErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [10:0] mem_addr_q;
    logic [10:0] mem_addr_d;
    logic [7:0]  shadow_q;
    logic [7:0]  shadow_d;
    logic        shadow_valid_q;
    logic        shadow_valid_d;
    logic [7:0]  active_q;
    logic [7:0]  active_d;
    logic        active_valid_q;
    logic        active_valid_d;
    logic        bit_disp_q;
    logic        bit_disp_d;
    logic        overrun_q;
    logic        overrun_d;
    logic        underrun_q;
    logic        underrun_d;
    logic        fetch_err_q;
    logic        fetch_err_d;

    logic        busy;
    logic        capture;
    logic        timeout_hit;
    logic        fill;
    logic [7:0]  fill_data;
    logic        cell_end;
    logic [7:0]  pix_by_col;

    assign busy     = (state_q != ST_IDLE);
    assign capture  = (state_q == ST_WAIT) && memAck;
    assign cell_end = (colCnt == 3'd7);

`ifdef GLYPH_ACK_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

    logic [3:0] tmo_cnt_q;
    logic [3:0] tmo_cnt_d;

    // Count WAIT cycles that pass without an acknowledge; cleared while in REQ
    // so every fetch starts its WAIT phase from zero.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_REQ) begin
            tmo_cnt_d = 4'd0;
        end else if ((state_q == ST_WAIT) && !memAck) begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= 4'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // The last allowed WAIT cycle expires only if memAck is absent in it,
    // so a late acknowledge still wins.
    assign timeout_hit = (state_q == ST_WAIT) && !memAck && (tmo_cnt_q == TMO_LAST);
`else
    // The limit only matters when the abort logic is built in.
    logic [3:0] unused_tmo_limit;
    assign unused_tmo_limit = 4'(ACK_TIMEOUT);
    assign timeout_hit      = 1'b0;
`endif

    // A completed fetch either brings memory data or, on abort, a blank row.
    assign fill      = capture || timeout_hit;
    assign fill_data = capture ? memData : 8'h00;

    // Reorder the active row so that index colCnt selects the on-screen pixel.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pix
            if (MSB_LEFT != 0) begin : g_msb_left
                assign pix_by_col[gi] = active_q[7 - gi];
            end else begin : g_lsb_left
                assign pix_by_col[gi] = active_q[gi];
            end
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (readEn) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: the request is held for the whole REQ/WAIT span.
    always_comb begin
        memReq = busy;
    end

    // Datapath next-state: address latch, row buffers, pixel and status pulses.
    always_comb begin
        mem_addr_d     = mem_addr_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;

        // A request only starts a fetch when idle; while busy it is dropped.
        if ((state_q == ST_IDLE) && readEn) begin
            mem_addr_d = {charCode, rowCnt};
        end

        if (cell_end) begin
            if (fill) begin
                // Row arriving exactly at the boundary bypasses the shadow.
                active_d       = fill_data;
                active_valid_d = 1'b1;
                shadow_valid_d = 1'b0;
            end else if (shadow_valid_q) begin
                active_d       = shadow_q;
                active_valid_d = 1'b1;
                shadow_valid_d = 1'b0;
            end
        end else if (fill) begin
            // Newer row silently replaces any shadow row not yet promoted.
            shadow_d       = fill_data;
            shadow_valid_d = 1'b1;
        end

        bit_disp_d  = active_valid_q && pix_by_col[colCnt];
        overrun_d   = readEn && busy;
        // Underruns are only meaningful once a row has been displayed.
        underrun_d  = cell_end && !fill && !shadow_valid_q && active_valid_q;
        fetch_err_d = timeout_hit;
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr_q     <= 11'd0;
            shadow_q       <= 8'h00;
            shadow_valid_q <= 1'b0;
            active_q       <= 8'h00;
            active_valid_q <= 1'b0;
            bit_disp_q     <= 1'b0;
            overrun_q      <= 1'b0;
            underrun_q     <= 1'b0;
            fetch_err_q    <= 1'b0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            bit_disp_q     <= bit_disp_d;
            overrun_q      <= overrun_d;
            underrun_q     <= underrun_d;
            fetch_err_q    <= fetch_err_d;
        end
    end

    assign memAddr  = mem_addr_q;
    assign bitDisp  = bit_disp_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;
    assign fetchErr = fetch_err_q;

endmodule

// File: tb/tb_char_glyph_server.sv
// Testbench for char_glyph_server: directed stimulus pushes expected values
// into a scoreboard keyed by cycle; a negedge monitor pops and compares them
// and checks every memory transaction address against an address queue.
module tb_char_glyph_server;

    logic        clock = 1'b0;
    logic        reset;
    logic        readEn;
    logic [3:0]  rowCnt;
    logic [2:0]  colCnt;
    logic [6:0]  charCode;
    logic        memReq;
    logic [10:0] memAddr;
    logic        memAck;
    logic [7:0]  memData;
    logic        bitDisp;
    logic        overrun;
    logic        underrun;
    logic        fetchErr;

    always #5 clock = ~clock;

    char_glyph_server #(
        .ACK_TIMEOUT (15),
        .MSB_LEFT    (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .readEn   (readEn),
        .rowCnt   (rowCnt),
        .colCnt   (colCnt),
        .charCode (charCode),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memAck   (memAck),
        .memData  (memData),
        .bitDisp  (bitDisp),
        .overrun  (overrun),
        .underrun (underrun),
        .fetchErr (fetchErr)
    );

    localparam int S_BIT  = 0;
    localparam int S_REQ  = 1;
    localparam int S_OVR  = 2;
    localparam int S_UND  = 3;
    localparam int S_ERR  = 4;
    localparam int S_ADDR = 5;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        keep[$];
    logic [10:0] addr_q[$];

    int cyc     = 0;
    int errors  = 0;
    int checks  = 0;
    int n_txn   = 0;
    int n_ovr   = 0;
    int n_und   = 0;
    int n_err   = 0;
    int exp_txn = 0;
    int exp_ovr = 0;
    int exp_und = 0;
    int exp_err = 0;
    int hold_n  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            S_BIT:   return "bitDisp";
            S_REQ:   return "memReq";
            S_OVR:   return "overrun";
            S_UND:   return "underrun";
            S_ERR:   return "fetchErr";
            default: return "memAddr";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_BIT:   return {31'd0, bitDisp};
            S_REQ:   return {31'd0, memReq};
            S_OVR:   return {31'd0, overrun};
            S_UND:   return {31'd0, underrun};
            S_ERR:   return {31'd0, fetchErr};
            default: return {21'd0, memAddr};
        endcase
    endfunction

    // Monitor: compare due expectations and every memory transaction.
    always @(negedge clock) begin
        logic [10:0] a;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                chk(sig_name(sb[i].sig), sig_val(sb[i].sig), sb[i].val);
            end else if (sb[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_%s: expectation for cycle %0d never checked", sig_name(sb[i].sig), sb[i].due);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
        if (!reset) begin
            if (memReq && memAck) begin
                n_txn++;
                $display("txn %0d: cycle=%0d addr=%03h data=%02h", n_txn, cyc, memAddr, memData);
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: actual addr=%03h required no transaction", memAddr);
                end else begin
                    a = addr_q.pop_front();
                    chk("txn_memAddr", {21'd0, memAddr}, {21'd0, a});
                end
            end
            if (overrun)  n_ovr++;
            if (underrun) n_und++;
            if (fetchErr) n_err++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int s, input logic [31:0] v, input int dly);
        sb.push_back('{due: cyc + dly, sig: s, val: v});
    endtask

    // Issue a fetch from IDLE; returns in the REQ cycle.
    task automatic issue(input logic [6:0] cc, input logic [3:0] rc, input bit txn);
        readEn   = 1'b1;
        charCode = cc;
        rowCnt   = rc;
        push_exp(S_REQ, 0, 0);
        if (txn) begin
            addr_q.push_back({cc, rc});
            exp_txn++;
        end
        step();
        readEn = 1'b0;
        push_exp(S_ADDR, {21'd0, cc, rc}, 0);
    endtask

    // From REQ: hold nwait WAIT cycles, then acknowledge with data.
    task automatic wait_ack(input int nwait, input logic [7:0] d);
        for (int k = 0; k < nwait + 1; k++) begin
            push_exp(S_REQ, 1, 0);
            step();
        end
        push_exp(S_REQ, 1, 0);
        memAck  = 1'b1;
        memData = d;
        step();
        memAck = 1'b0;
        push_exp(S_REQ, 0, 0);
    endtask

    // One cell: colCnt 0..7, bitDisp follows the shown row one cycle late.
    task automatic sweep(input logic [7:0] shown, input bit und);
        for (int c = 0; c < 8; c++) begin
            colCnt = 3'(c);
            push_exp(S_BIT, {31'd0, shown[7 - c]}, 1);
            push_exp(S_UND, (c == 7 && und) ? 1 : 0, 1);
            if (c == 7 && und) exp_und++;
            step();
        end
        colCnt = 3'd0;
    endtask

    initial begin
        reset    = 1'b1;
        readEn   = 1'b0;
        rowCnt   = 4'd0;
        colCnt   = 3'd0;
        charCode = 7'd0;
        memAck   = 1'b0;
        memData  = 8'h00;

        // Reset state.
        step();
        step();
        push_exp(S_BIT, 0, 0);
        push_exp(S_REQ, 0, 0);
        push_exp(S_ADDR, 0, 0);
        push_exp(S_OVR, 0, 0);
        push_exp(S_UND, 0, 0);
        push_exp(S_ERR, 0, 0);
        step();

        // Acknowledge in the first cycle after release must be ignored.
        reset   = 1'b0;
        memAck  = 1'b1;
        memData = 8'hFF;
        step();
        memAck = 1'b0;
        sweep(8'h00, 1'b0);
        sweep(8'h00, 1'b0);

        // Basic fetch 'A' row 3, ack after two WAIT cycles.
        issue(7'h41, 4'h3, 1'b1);
        push_exp(S_ADDR, 11'h413, 0);
        wait_ack(2, 8'h81);
        sweep(8'h00, 1'b0);
        sweep(8'h81, 1'b1);

        // Capture and swap in the same cycle.
        issue(7'h12, 4'h5, 1'b1);
        push_exp(S_REQ, 1, 0);
        step();
        push_exp(S_REQ, 1, 0);
        step();
        colCnt  = 3'd7;
        memAck  = 1'b1;
        memData = 8'hF0;
        push_exp(S_BIT, 1, 1);
        push_exp(S_UND, 0, 1);
        step();
        memAck = 1'b0;
        colCnt = 3'd0;
        push_exp(S_REQ, 0, 0);
        sweep(8'hF0, 1'b1);

        // Overrun: second readEn in the REQ cycle is dropped.
        readEn   = 1'b1;
        charCode = 7'h2A;
        rowCnt   = 4'h6;
        addr_q.push_back(11'h2A6);
        exp_txn++;
        step();
        charCode = 7'h15;
        rowCnt   = 4'h9;
        push_exp(S_OVR, 1, 1);
        push_exp(S_ADDR, 11'h2A6, 0);
        push_exp(S_REQ, 1, 0);
        exp_ovr++;
        step();
        readEn = 1'b0;
        push_exp(S_OVR, 0, 1);
        push_exp(S_ADDR, 11'h2A6, 0);
        push_exp(S_REQ, 1, 0);
        memAck  = 1'b1;
        memData = 8'hAA;
        step();
        memAck = 1'b0;
        push_exp(S_REQ, 0, 0);
        step();
        push_exp(S_REQ, 0, 0);
        push_exp(S_ADDR, 11'h2A6, 0);

        // Underrun over two cells repeating 8'hAA.
        sweep(8'hF0, 1'b0);
        sweep(8'hAA, 1'b1);
        sweep(8'hAA, 1'b1);

        // Address boundary and overwrite of an unswapped shadow row.
        issue(7'h7F, 4'hF, 1'b1);
        push_exp(S_ADDR, 11'h7FF, 0);
        wait_ack(0, 8'h3C);
        issue(7'h00, 4'h0, 1'b1);
        wait_ack(1, 8'h5A);
        sweep(8'hAA, 1'b0);
        sweep(8'h5A, 1'b1);

`ifdef GLYPH_ACK_TIMEOUT_EN
        // No acknowledge: abort after the 15th WAIT cycle.
        issue(7'h30, 4'h1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            push_exp(S_REQ, 1, 0);
            push_exp(S_ERR, (k == 15) ? 1 : 0, 1);
            step();
        end
        exp_err++;
        push_exp(S_REQ, 0, 0);
        sweep(8'h5A, 1'b0);
        sweep(8'h00, 1'b1);

        // Acknowledge in the 15th WAIT cycle beats the timeout.
        issue(7'h31, 4'h2, 1'b1);
        for (int k = 0; k < 15; k++) begin
            push_exp(S_REQ, 1, 0);
            push_exp(S_ERR, 0, 1);
            step();
        end
        push_exp(S_REQ, 1, 0);
        push_exp(S_ERR, 0, 1);
        memAck  = 1'b1;
        memData = 8'hC3;
        step();
        memAck = 1'b0;
        push_exp(S_REQ, 0, 0);
        sweep(8'h00, 1'b0);
        sweep(8'hC3, 1'b1);
        hold_n = 4;
`else
        hold_n = 20;
`endif

        // Unacknowledged fetch held in WAIT, then reset mid-fetch.
        issue(7'h10, 4'h0, 1'b0);
        colCnt = 3'd1;
        for (int k = 0; k < hold_n; k++) begin
            push_exp(S_REQ, 1, 0);
            push_exp(S_ERR, 0, 1);
            if (k < hold_n - 1) push_exp(S_BIT, 1, 1);
            step();
        end
        chk("bitDisp_before_reset", {31'd0, bitDisp}, 1);
        reset = 1'b1;
        #1;
        chk("memReq_async_reset", {31'd0, memReq}, 0);
        chk("bitDisp_async_reset", {31'd0, bitDisp}, 0);
        step();
        step();
        reset   = 1'b0;
        colCnt  = 3'd0;
        memAck  = 1'b1;
        memData = 8'hFF;
        push_exp(S_REQ, 0, 0);
        step();
        memAck = 1'b0;
        sweep(8'h00, 1'b0);
        sweep(8'h00, 1'b0);
        step();
        step();

        chk("txn_count", n_txn, exp_txn);
        chk("overrun_count", n_ovr, exp_ovr);
        chk("underrun_count", n_und, exp_und);
        chk("fetchErr_count", n_err, exp_err);
        chk("scoreboard_drained", sb.size(), 0);
        chk("addr_queue_drained", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
